// File: rtl/data_mem_pkg.sv
// Shared types and constants for the vector data memory arbiter.
// A memory word is 6 lanes of 8 bits; the word index is the byte address without its low 2 bits.
package data_mem_pkg;
    localparam int ADDR_W       = 14;
    localparam int WORD_IDX_W   = ADDR_W - 2;
    localparam int LANES        = 6;
    localparam int LANE_W       = 8;
    localparam int LEN_W        = 5;
    localparam int BURST_MAX    = 16;
    localparam int STARVE_LIMIT = 8;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef logic [LANES-1:0][LANE_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        DMA_BURST,
        DMA_FLUSH
    } arb_state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : len;
    endfunction
endpackage

// File: rtl/dma_burst_gen.sv
// Burst address generator: latches the start word index and length on load, then
// advances one word per step, wrapping naturally at the top of the word space.
module dma_burst_gen
    import data_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [WORD_IDX_W-1:0] start_idx,
    input  logic [LEN_W-1:0]      len,
    output logic [WORD_IDX_W-1:0] idx,
    output logic                  last
);
    logic [LEN_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            remaining <= '0;
        end else if (load) begin
            idx       <= start_idx;
            remaining <= clamp_len(len);
        end else if (step) begin
            idx       <= idx + WORD_IDX_W'(1);
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign last = (remaining == LEN_W'(1));
endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: CPU single-word accesses granted same cycle,
// DMA non-preemptible bursts, and a starvation counter that forces DMA progress.
module data_mem_arbiter
    import data_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  word_t             cpu_wdata,
    output logic              cpu_gnt,
    output word_t             cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    output logic              dma_gnt,
    output logic              dma_wready,
    input  word_t             dma_wdata,
    output word_t             dma_rdata,
    output logic              dma_rvalid,
    output logic              dma_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output word_t             mem_wd,
    input  word_t             mem_rd,
    output arb_state_t        state
);
    // Handshake: dma_req is held with a stable descriptor until the single-cycle
    // dma_gnt pulse; dma_wready marks the cycle a write beat consumes dma_wdata.
    arb_state_t            state_next;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  dma_we_q;
    logic                  beat;
    logic                  last_beat;
    logic [WORD_IDX_W-1:0] beat_idx;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[1:0], dma_addr[1:0]};

    dma_burst_gen u_burst (
        .clk       (clk),
        .rst       (rst),
        .load      (dma_gnt),
        .step      (beat),
        .start_idx (dma_addr[ADDR_W-1:2]),
        .len       (dma_len),
        .idx       (beat_idx),
        .last      (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        dma_wready = 1'b0;
        dma_done   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wd     = '0;
        beat       = 1'b0;
        // Reset is synchronous, so the combinational outputs are held quiet while it is asserted.
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (dma_req && (!cpu_req || starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
                        dma_gnt    = 1'b1;
                        state_next = (clamp_len(dma_len) == '0) ? DMA_FLUSH : DMA_BURST;
                    end else begin
                        cpu_gnt = cpu_req;
                    end
                end
                DMA_BURST: begin
                    beat     = 1'b1;
                    mem_addr = {beat_idx, 2'b00};
                    if (dma_we_q) begin
                        dma_wready = 1'b1;
                        mem_we     = 1'b1;
                        mem_wd     = dma_wdata;
                    end
                    if (last_beat) state_next = DMA_FLUSH;
                end
                DMA_FLUSH: begin
                    dma_done   = 1'b1;
                    cpu_gnt    = cpu_req;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
            if (cpu_gnt) begin
                mem_we   = cpu_we;
                mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00};
                mem_wd   = cpu_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            dma_we_q   <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            if (cpu_gnt && !cpu_we) cpu_rdata <= mem_rd;
            dma_rvalid <= beat && !dma_we_q;
            if (beat && !dma_we_q) dma_rdata <= mem_rd;
            if (dma_gnt) dma_we_q <= dma_we;
            if (dma_gnt || !dma_req)
                starve_cnt <= '0;
            else if (state == IDLE && cpu_gnt && starve_cnt != STARVE_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model (cycles-left counter and a reference memory).
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, dma_req, dma_we;
    logic [ADDR_W-1:0] cpu_addr, dma_addr;
    logic [LEN_W-1:0]  dma_len;
    word_t             cpu_wdata, dma_wdata;
    logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_wready, dma_rvalid, dma_done, mem_we;
    word_t             cpu_rdata, dma_rdata, mem_wd, mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    arb_state_t        dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    word_t mem     [4096];
    word_t ref_mem [4096];

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_gnt(dma_gnt), .dma_wready(dma_wready), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .state(dbg_state)
    );

    // Single-port memory with combinational read
    assign mem_rd = mem[mem_addr[13:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[13:2]] <= mem_wd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic word_t rand_word();
        return word_t'({$urandom(), 16'($urandom())});
    endfunction

    // ---------------- behavioural model and per-cycle compare ----------------
    int                    m_left   = 0;   // cycles until the DMA transaction is over (beats + flush)
    int                    m_starve = 0;
    logic [WORD_IDX_W-1:0] m_idx    = '0;
    logic                  m_we     = 1'b0;
    bit                    e_cpu_rv = 1'b0, e_dma_rv = 1'b0;
    word_t                 e_cpu_rd = '0,   e_dma_rd = '0;

    always @(negedge clk) begin
        bit                cgnt, dgnt, wrdy, done, we, acc, cpu_ok, n_cpu_rv, n_dma_rv;
        logic [ADDR_W-1:0] addr;
        word_t             wd, n_cpu_rd, n_dma_rd;
        arb_state_t        e_state;
        int                blen;
        cgnt = 0; dgnt = 0; wrdy = 0; done = 0; we = 0; acc = 0; cpu_ok = 0;
        n_cpu_rv = 0; n_dma_rv = 0; addr = '0; wd = '0;
        n_cpu_rd = e_cpu_rd; n_dma_rd = e_dma_rd;
        e_state = (m_left == 0) ? IDLE : (m_left == 1) ? DMA_FLUSH : DMA_BURST;

        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(e_cpu_rv));
        if (e_cpu_rv) chk("cpu_rdata", 64'(cpu_rdata), 64'(e_cpu_rd));
        chk("dma_rvalid", 64'(dma_rvalid), 64'(e_dma_rv));
        if (e_dma_rv) chk("dma_rdata", 64'(dma_rdata), 64'(e_dma_rd));
        chk("state", 64'(dbg_state), 64'(e_state));

        if (rst) begin
            m_left = 0; m_starve = 0; n_cpu_rd = '0; n_dma_rd = '0;
        end else begin
            if (m_left == 0) begin
                if (dma_req && (!cpu_req || m_starve == 8)) begin
                    dgnt     = 1;
                    blen     = (int'(dma_len) > 16) ? 16 : int'(dma_len);
                    m_idx    = dma_addr[13:2];
                    m_we     = dma_we;
                    m_left   = blen + 1;
                    m_starve = 0;
                end else if (cpu_req) begin
                    cpu_ok = 1;
                    if (dma_req && m_starve < 8) m_starve++;
                end
            end else if (m_left == 1) begin
                done   = 1;
                cpu_ok = cpu_req;
                m_left = 0;
            end else begin
                acc  = 1;
                addr = {m_idx, 2'b00};
                if (m_we) begin
                    we = 1; wrdy = 1; wd = dma_wdata;
                    ref_mem[m_idx] = dma_wdata;
                end else begin
                    n_dma_rv = 1;
                    n_dma_rd = ref_mem[m_idx];
                end
                m_idx = m_idx + 12'd1;
                m_left--;
            end
            if (cpu_ok) begin
                cgnt = 1; acc = 1;
                addr = {cpu_addr[13:2], 2'b00};
                if (cpu_we) begin
                    we = 1; wd = cpu_wdata;
                    ref_mem[cpu_addr[13:2]] = cpu_wdata;
                end else begin
                    n_cpu_rv = 1;
                    n_cpu_rd = ref_mem[cpu_addr[13:2]];
                end
            end
            if (!dma_req) m_starve = 0;
        end

        chk("cpu_gnt", 64'(cpu_gnt), 64'(cgnt));
        chk("dma_gnt", 64'(dma_gnt), 64'(dgnt));
        chk("dma_wready", 64'(dma_wready), 64'(wrdy));
        chk("dma_done", 64'(dma_done), 64'(done));
        chk("mem_we", 64'(mem_we), 64'(we));
        if (acc) chk("mem_addr", 64'(mem_addr), 64'(addr));
        if (we)  chk("mem_wd", 64'(mem_wd), 64'(wd));

        e_cpu_rv = n_cpu_rv; e_cpu_rd = n_cpu_rd;
        e_dma_rv = n_dma_rv; e_dma_rd = n_dma_rd;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_len = '0;
    endtask

    initial begin
        int idx3 [3];
        bit pending;
        idx3[0] = 4094; idx3[1] = 4095; idx3[2] = 0;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = rand_word();
            ref_mem[i] = mem[i];
        end
        rst = 1; idle_inputs();
        cpu_wdata = '0; dma_wdata = rand_word();
        step(); step();
        rst = 0;
        mid();
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'h0);
        chk("rst_dma_rdata", 64'(dma_rdata), 64'h0);
        chk("rst_mem_we", 64'(mem_we), 64'h0);

        // CPU write then read back at 0x0010
        step();
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0010; cpu_wdata = word_t'(48'h0A0B0C0D0E0F);
        mid();
        chk("t1_wr_gnt", 64'(cpu_gnt), 64'h1);
        chk("t1_wr_addr", 64'(mem_addr), 64'h10);
        step();
        cpu_we = 0;
        mid();
        chk("t1_rd_gnt", 64'(cpu_gnt), 64'h1);
        step();
        cpu_req = 0;
        mid();
        chk("t1_rvalid", 64'(cpu_rvalid), 64'h1);
        chk("t1_rdata", 64'(cpu_rdata), 64'h0A0B0C0D0E0F);

        // DMA write burst 0x0020 len 4
        step();
        dma_req = 1; dma_we = 1; dma_addr = 14'h0020; dma_len = 5'd4;
        mid();
        chk("t2_gnt", 64'(dma_gnt), 64'h1);
        step();
        dma_req = 0;
        for (int k = 0; k < 4; k++) begin
            dma_wdata = rand_word();
            mid();
            chk("t2_we", 64'(mem_we), 64'h1);
            chk("t2_idx", 64'(mem_addr[13:2]), 64'(8 + k));
            step();
        end
        mid();
        chk("t2_done", 64'(dma_done), 64'h1);

        // DMA read burst across the top of the word space
        step();
        dma_req = 1; dma_we = 0; dma_addr = 14'h3FF8; dma_len = 5'd3;
        mid();
        chk("t3_gnt", 64'(dma_gnt), 64'h1);
        step();
        dma_req = 0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t3_idx", 64'(mem_addr[13:2]), 64'(idx3[k]));
            chk("t3_rvalid", 64'(dma_rvalid), 64'(k > 0));
            step();
        end
        mid();
        chk("t3_done", 64'(dma_done), 64'h1);
        chk("t3_last_rvalid", 64'(dma_rvalid), 64'h1);

        // Starvation: continuous CPU reads, DMA wins on the 9th cycle
        step();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0040;
        dma_req = 1; dma_we = 1; dma_addr = 14'h0100; dma_len = 5'd2;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("t4_cpu_first", 64'({cpu_gnt, dma_gnt}), 64'b10);
            step();
        end
        mid();
        chk("t4_dma_wins", 64'({cpu_gnt, dma_gnt}), 64'b01);
        step();
        dma_req = 0;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("t4_cpu_stall", 64'(cpu_gnt), 64'h0);
            step();
        end
        mid();
        chk("t4_flush_cpu", 64'({cpu_gnt, dma_done}), 64'b11);

        // Zero-length burst
        step();
        idle_inputs();
        dma_req = 1; dma_we = 0; dma_addr = 14'h0200; dma_len = 5'd0;
        mid();
        chk("t5_gnt", 64'(dma_gnt), 64'h1);
        step();
        dma_req = 0;
        mid();
        chk("t5_done", 64'({dma_done, mem_we, dma_rvalid}), 64'b100);
        step();
        mid();
        chk("t5_no_rvalid", 64'({dma_done, dma_rvalid}), 64'b00);

        // Reset at beat 2 of a len-8 write burst
        step();
        dma_req = 1; dma_we = 1; dma_addr = 14'h0300; dma_len = 5'd8;
        mid();
        chk("t6_gnt", 64'(dma_gnt), 64'h1);
        step();
        dma_req = 0;
        step();
        step();
        rst = 1;
        mid();
        chk("t6_rst_we", 64'(mem_we), 64'h0);
        step();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk("t6_quiet", 64'({mem_we, dma_done, dma_wready, dma_gnt, cpu_gnt}), 64'h0);
            step();
        end

        // Randomized traffic with varying CPU load
        pending = 0;
        for (int c = 0; c < 4000; c++) begin
            int load_pct;
            load_pct = (c < 1500) ? 95 : (c < 3000) ? 40 : 70;
            mid();
            if (dma_gnt) pending = 0;
            step();
            rst = ($urandom_range(0, 499) == 0);
            if (!pending && $urandom_range(0, 5) == 0) begin
                pending  = 1;
                dma_we   = $urandom_range(0, 1) == 1;
                dma_addr = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(16'h3FC0, 16'h3FFF))
                                                      : 14'($urandom_range(0, 16'h00FF));
                dma_len  = 5'($urandom_range(0, 20));
            end
            dma_req   = pending;
            dma_wdata = rand_word();
            cpu_req   = $urandom_range(0, 99) < load_pct;
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = ($urandom_range(0, 3) == 0) ? 14'($urandom()) : 14'($urandom_range(0, 16'h00FF));
            cpu_wdata = rand_word();
        end
        rst = 0;
        idle_inputs();
        step(); step(); step();
        mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port vector data memory (6 lanes x 8 bit per word, 14-bit byte address, word index = addr[13:2]) between the vector CPU load/store path and a DMA/host loader port.
- CPU gets single-word accesses with a same-cycle grant.
- DMA gets non-preemptible auto-incrementing bursts.
- A starvation counter guarantees DMA progress under continuous CPU traffic.
- Sits between the CPU memory stage, the DMA loader and the data memory instance.

Parameters:
ADDR_W, 14, byte address width; word index is ADDR_W-2 = 12 bits.
LANES, 6, lanes per memory word.
LANE_W, 8, bits per lane.
BURST_MAX, 16, maximum DMA burst length in words.
STARVE_LIMIT, 8, consecutive denied DMA cycles before DMA wins over CPU.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request (single word)
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  14  CPU byte address; bits [1:0] ignored
cpu_wdata  in  6x8  CPU write word
cpu_gnt  out  1  access performed at this clock edge (combinational)
cpu_rdata  out  6x8  registered read word
cpu_rvalid  out  1  cpu_rdata valid (one cycle after a granted read)
dma_req  in  1  burst request; held until dma_gnt
dma_we  in  1  burst direction
dma_addr  in  14  burst start byte address
dma_len  in  5  burst length in words, 0..BURST_MAX
dma_gnt  out  1  one-cycle pulse: burst accepted, descriptor latched
dma_wready  out  1  write beat consumes dma_wdata this cycle
dma_wdata  in  6x8  DMA write word
dma_rdata  out  6x8  registered read word
dma_rvalid  out  1  dma_rdata valid
dma_done  out  1  one-cycle pulse at burst completion
mem_we  out  1  to data memory WE
mem_addr  out  14  to data memory A; low 2 bits driven 0
mem_wd  out  6x8  to data memory WD
mem_rd  in  6x8  from data memory RD (combinational read)

Behaviour:
- States: IDLE, DMA_BURST, DMA_FLUSH.
- Reset: state IDLE, starve_cnt 0; cpu_rvalid, dma_rvalid, dma_done, dma_gnt, dma_wready, cpu_gnt and mem_we all 0; rdata registers 0. Reset mid-burst aborts the burst with no dma_done and no further writes.
- IDLE arbitration:
  - DMA wins if dma_req and (!cpu_req or starve_cnt == STARVE_LIMIT).
  - Otherwise, cpu_req wins.
- CPU win: cpu_gnt=1 the same cycle; mem_we=cpu_we, mem_addr={cpu_addr[13:2],2'b00}, mem_wd=cpu_wdata. A read registers mem_rd into cpu_rdata; cpu_rvalid=1 the next cycle. Back-to-back CPU accesses run every cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, in each IDLE cycle where dma_req=1 and the CPU wins.
  - Cleared on dma_gnt and when dma_req=0.
- DMA win: dma_gnt pulse; latch word index = dma_addr[13:2] and len; no memory access that cycle.
  - len==0: go to DMA_FLUSH.
  - len>0: go to DMA_BURST.
  - dma_len > BURST_MAX is clamped to BURST_MAX.
- DMA_BURST: one beat per cycle; cpu_gnt=0 throughout (CPU stalls).
  - Write beat: dma_wready=1, mem_we=1, mem_wd=dma_wdata.
  - Read beat: mem_we=0; dma_rdata and dma_rvalid are registered for the next cycle.
  - After each beat, word index +1 modulo 4096 (4095 wraps to 0) and remaining -1.
  - After the last beat, go to DMA_FLUSH.
- DMA_FLUSH (1 cycle): dma_done=1, coinciding with the last dma_rvalid for reads. CPU arbitration is already active this cycle (CPU has priority; DMA cannot be re-granted until IDLE). Then go to IDLE.
- Total burst latency from dma_gnt to dma_done = len+1 cycles.
- mem_we is never asserted outside a granted CPU write or a DMA write beat.

Decomposition:
- Package data_mem_pkg holds:
  - word_t = logic [LANES-1:0][LANE_W-1:0]
  - ADDR_W and WORD_IDX_W=12
  - BURST_MAX and STARVE_LIMIT defaults
  - arb_state_t enum {IDLE, DMA_BURST, DMA_FLUSH}
- One sub-module, dma_burst_gen, holds the latched word index, remaining count, wrap-around increment and last-beat flag.
- Arbitration and output muxing stay in data_mem_arbiter.

Test Plan:
1. CPU write 0x0A0B0C0D0E0F at addr 0x0010, then read 0x0010 -> cpu_gnt same cycle both times; cpu_rvalid one cycle after the read with the same data.
2. DMA write burst, addr 0x0020, len 4, no CPU traffic -> dma_gnt at cycle t; mem_we at t+1..t+4 on word indices 8,9,10,11; dma_done at t+5.
3. DMA read burst, addr 0x3FF8, len 3 -> word indices 4094, 4095, 0; three dma_rvalid pulses; dma_done with the third.
4. cpu_req held continuously, dma_req raised -> CPU granted 8 cycles, 9th cycle dma_gnt; cpu_gnt=0 through the burst; CPU resumes in the DMA_FLUSH cycle.
5. dma_len=0 -> dma_gnt, then dma_done next cycle; no mem_we, no dma_rvalid.
6. rst asserted at beat 2 of a len-8 write burst -> next cycle IDLE; no further mem_we; dma_done never pulses; all outputs 0.
